// File: rtl/bcp_engine.sv
// bcp_engine: Boolean-constraint-propagation responder.
//
// Clause indices arrive from the controller on bcp_en/bcp_clause_idx and are
// buffered in a small circular queue. One clause at a time is fetched from the
// clause database and its literals are classified against the variable state
// table. A unit clause pushes its remaining literal as an implication, and a
// clause with every literal false raises a sticky conflict and flushes the
// queue. A satisfied clause stops evaluation at the first true literal.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   bcp_en                one-cycle strobe, enqueue bcp_clause_idx
//   bcp_clause_idx        clause index to evaluate
//   reset_bcp             synchronous flush of queue, FSM and sticky flags
//   bcp_busy              queue non-empty or a clause in flight
//   conflict              sticky, some clause had all literals false
//   bcp_overflow          sticky, a strobe arrived while the queue was full
//   cdb_read/cdb_addr     clause database read request
//   cdb_data              clause data, slot k = {valid, neg, var}
//   read_vs/var_in_vs     variable state read request
//   val_out_vs            variable value
//   unassign_out_vs       variable is unassigned
//   push_imply            implication push strobe
//   var_in_imply          implied variable
//   val_in_imply          implied value
//   type_in_imply         implication type, constant 1 (implied)
//   full_imply            implication queue full
//
// Memory-style inputs (cdb_data, val_out_vs, unassign_out_vs) are sampled in
// the cycle where the corresponding registered strobe is high.
module bcp_engine #(
  parameter int LITS             = 3,
  parameter int QDEPTH           = 8,
  parameter int MAX_CLAUSES_BITS = 8,
  parameter int MAX_VARS_BITS    = 6
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                bcp_en,
  input  logic [MAX_CLAUSES_BITS-1:0]         bcp_clause_idx,
  input  logic                                reset_bcp,
  output logic                                bcp_busy,
  output logic                                conflict,
  output logic                                bcp_overflow,
  output logic                                cdb_read,
  output logic [MAX_CLAUSES_BITS-1:0]         cdb_addr,
  input  logic [LITS*(MAX_VARS_BITS+2)-1:0]   cdb_data,
  output logic                                read_vs,
  output logic [MAX_VARS_BITS-1:0]            var_in_vs,
  input  logic                                val_out_vs,
  input  logic                                unassign_out_vs,
  output logic                                push_imply,
  output logic [MAX_VARS_BITS-1:0]            var_in_imply,
  output logic                                val_in_imply,
  output logic                                type_in_imply,
  input  logic                                full_imply
);

  localparam int SLOT_W = MAX_VARS_BITS + 2;
  localparam int CL_W   = LITS * SLOT_W;
  localparam int KW     = (LITS > 1) ? $clog2(LITS) : 1;
  localparam int PW     = $clog2(QDEPTH);
  localparam int CW     = PW + 1;

  localparam logic [KW-1:0] K_LAST = KW'(LITS - 1);
  localparam logic [CW-1:0] Q_FULL = CW'(QDEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CL_READ  = 3'd1;
  localparam logic [2:0] S_LIT_READ = 3'd2;
  localparam logic [2:0] S_LIT_EVAL = 3'd3;
  localparam logic [2:0] S_RESOLVE  = 3'd4;
  localparam logic [2:0] S_PUSH     = 3'd5;

  // Unassigned-literal counter only needs to distinguish 0, 1 and "2 or more".
  function automatic logic [1:0] sat_inc2(input logic [1:0] n);
    return (n == 2'd2) ? 2'd2 : n + 2'd1;
  endfunction

  logic [2:0]                  state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic [1:0]                  nun_q, nun_d;
  logic [MAX_VARS_BITS-1:0]    unit_var_q, unit_var_d;
  logic                        unit_neg_q, unit_neg_d;
  logic [CL_W-1:0]             clause_q, clause_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        busy_q, busy_d;
  logic                        conflict_q, conflict_d;
  logic                        ovf_q, ovf_d;
  logic                        cdb_read_q, cdb_read_d;
  logic [MAX_CLAUSES_BITS-1:0] cdb_addr_q, cdb_addr_d;
  logic                        read_vs_q, read_vs_d;
  logic [MAX_VARS_BITS-1:0]    var_in_vs_q, var_in_vs_d;
  logic                        push_q, push_d;
  logic [MAX_VARS_BITS-1:0]    imply_var_q, imply_var_d;
  logic                        imply_val_q, imply_val_d;

  logic [MAX_CLAUSES_BITS-1:0] q_mem [QDEPTH];

  logic                        deq, enq, flush;
  logic                        q_empty, q_full;
  logic [SLOT_W-1:0]           slot_cur;
  logic                        slot_valid, slot_neg;
  logic [MAX_VARS_BITS-1:0]    slot_var;

  assign q_empty    = (cnt_q == '0);
  assign q_full     = (cnt_q == Q_FULL);
  assign slot_cur   = clause_q[int'(k_q) * SLOT_W +: SLOT_W];
  assign slot_valid = slot_cur[SLOT_W-1];
  assign slot_neg   = slot_cur[SLOT_W-2];
  assign slot_var   = slot_cur[MAX_VARS_BITS-1:0];

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    nun_d       = nun_q;
    unit_var_d  = unit_var_q;
    unit_neg_d  = unit_neg_q;
    clause_d    = clause_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    conflict_d  = conflict_q;
    ovf_d       = ovf_q;
    cdb_read_d  = 1'b0;
    cdb_addr_d  = cdb_addr_q;
    read_vs_d   = 1'b0;
    var_in_vs_d = var_in_vs_q;
    push_d      = 1'b0;
    imply_var_d = imply_var_q;
    imply_val_d = imply_val_q;
    deq         = 1'b0;
    enq         = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!q_empty && !conflict_q && !reset_bcp) begin
          deq        = 1'b1;
          cdb_read_d = 1'b1;
          cdb_addr_d = q_mem[rd_ptr_q];
          state_d    = S_CL_READ;
        end
      end
      S_CL_READ: begin
        clause_d = cdb_data;
        k_d      = '0;
        nun_d    = 2'd0;
        state_d  = S_LIT_READ;
      end
      S_LIT_READ: begin
        if (slot_valid) begin
          read_vs_d   = 1'b1;
          var_in_vs_d = slot_var;
          state_d     = S_LIT_EVAL;
        end else if (k_q == K_LAST) begin
          state_d = S_RESOLVE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_LIT_EVAL: begin
        if (!unassign_out_vs && (val_out_vs != slot_neg)) begin
          // A true literal satisfies the clause; nothing left to learn from it.
          state_d = S_IDLE;
        end else begin
          if (unassign_out_vs) begin
            nun_d = sat_inc2(nun_q);
            if (nun_q == 2'd0) begin
              unit_var_d = slot_var;
              unit_neg_d = slot_neg;
            end
          end
          if (k_q == K_LAST) begin
            state_d = S_RESOLVE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_LIT_READ;
          end
        end
      end
      S_RESOLVE: begin
        if (nun_q == 2'd0) begin
          conflict_d = 1'b1;
          flush      = 1'b1;
          state_d    = S_IDLE;
        end else if (nun_q == 2'd1) begin
          // Load the implication now so it is stable for the whole stall.
          imply_var_d = unit_var_q;
          imply_val_d = ~unit_neg_q;
          state_d     = S_PUSH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUSH: begin
        if (!full_imply) begin
          push_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Indices are silently dropped while a conflict is pending or being raised.
    if (bcp_en && !conflict_q && !flush && !reset_bcp) begin
      if (!q_full || deq) begin
        enq = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    rd_ptr_d = rd_ptr_q + PW'(deq);
    wr_ptr_d = wr_ptr_q + PW'(enq);
    cnt_d    = cnt_q + CW'(enq) - CW'(deq);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end

    if (reset_bcp) begin
      state_d    = S_IDLE;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      conflict_d = 1'b0;
      ovf_d      = 1'b0;
      cdb_read_d = 1'b0;
      read_vs_d  = 1'b0;
      push_d     = 1'b0;
    end

    // Busy is registered from next state so it drops together with the FSM.
    busy_d = (cnt_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      nun_q       <= 2'd0;
      unit_var_q  <= '0;
      unit_neg_q  <= 1'b0;
      clause_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      conflict_q  <= 1'b0;
      ovf_q       <= 1'b0;
      cdb_read_q  <= 1'b0;
      cdb_addr_q  <= '0;
      read_vs_q   <= 1'b0;
      var_in_vs_q <= '0;
      push_q      <= 1'b0;
      imply_var_q <= '0;
      imply_val_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      nun_q       <= nun_d;
      unit_var_q  <= unit_var_d;
      unit_neg_q  <= unit_neg_d;
      clause_q    <= clause_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      conflict_q  <= conflict_d;
      ovf_q       <= ovf_d;
      cdb_read_q  <= cdb_read_d;
      cdb_addr_q  <= cdb_addr_d;
      read_vs_q   <= read_vs_d;
      var_in_vs_q <= var_in_vs_d;
      push_q      <= push_d;
      imply_var_q <= imply_var_d;
      imply_val_q <= imply_val_d;
    end
  end

  // Queue storage carries data only; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (enq) begin
      q_mem[wr_ptr_q] <= bcp_clause_idx;
    end
  end

  assign bcp_busy      = busy_q;
  assign conflict      = conflict_q;
  assign bcp_overflow  = ovf_q;
  assign cdb_read      = cdb_read_q;
  assign cdb_addr      = cdb_addr_q;
  assign read_vs       = read_vs_q;
  assign var_in_vs     = var_in_vs_q;
  assign push_imply    = push_q;
  assign var_in_imply  = imply_var_q;
  assign val_in_imply  = imply_val_q;
  assign type_in_imply = 1'b1;

endmodule

// File: tb/tb_bcp_engine.sv
// tb_bcp_engine: scoreboard bench for bcp_engine.
// Clause database and variable state table are modelled as arrays answering
// in the cycle their strobe is high. The reference model decides each
// clause's outcome directly from clause semantics (any true literal ->
// satisfied, else count unassigned literals) and queues the expected reads
// and pushes; a monitor pops and compares whenever the DUT strobes.
module tb_bcp_engine;
  localparam int LITS = 3;
  localparam int QDEPTH = 8;
  localparam int CB = 8;
  localparam int VB = 6;
  localparam int SW = VB + 2;
  localparam int CLW = LITS * SW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic bcp_en = 1'b0;
  logic [CB-1:0] bcp_clause_idx = '0;
  logic reset_bcp = 1'b0;
  logic full_imply = 1'b0;
  logic bcp_busy, conflict, bcp_overflow, cdb_read, read_vs;
  logic [CB-1:0] cdb_addr;
  logic [CLW-1:0] cdb_data;
  logic [VB-1:0] var_in_vs, var_in_imply;
  logic val_out_vs, unassign_out_vs;
  logic push_imply, val_in_imply, type_in_imply;

  logic [CLW-1:0] cmem [256];
  logic vval [64];
  logic vuna [64];

  assign cdb_data        = cdb_read ? cmem[cdb_addr] : '1;
  assign val_out_vs      = read_vs ? vval[var_in_vs] : 1'b1;
  assign unassign_out_vs = read_vs ? vuna[var_in_vs] : 1'b0;

  bcp_engine #(.LITS(LITS), .QDEPTH(QDEPTH), .MAX_CLAUSES_BITS(CB), .MAX_VARS_BITS(VB)) dut (
    .clock(clock), .reset(reset), .bcp_en(bcp_en), .bcp_clause_idx(bcp_clause_idx),
    .reset_bcp(reset_bcp), .bcp_busy(bcp_busy), .conflict(conflict),
    .bcp_overflow(bcp_overflow), .cdb_read(cdb_read), .cdb_addr(cdb_addr),
    .cdb_data(cdb_data), .read_vs(read_vs), .var_in_vs(var_in_vs),
    .val_out_vs(val_out_vs), .unassign_out_vs(unassign_out_vs),
    .push_imply(push_imply), .var_in_imply(var_in_imply), .val_in_imply(val_in_imply),
    .type_in_imply(type_in_imply), .full_imply(full_imply));

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int n_push = 0;
  int exp_rd[$];
  int exp_push[$];
  bit m_conf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic fail_timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  function automatic logic [SW-1:0] lit(input bit valid, input bit neg, input int v);
    return {valid, neg, VB'(v)};
  endfunction

  function automatic logic [CLW-1:0] cls(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                         input logic [SW-1:0] c);
    return {c, b, a};
  endfunction

  // kind: 0 = no action, 1 = unit (push v/val), 2 = conflict
  function automatic void eval_clause(input int idx, output int kind, output int v, output bit val);
    logic [CLW-1:0] c;
    logic [SW-1:0] s;
    int nun;
    bit sat;
    int vr;
    c = cmem[idx];
    nun = 0;
    sat = 1'b0;
    v = 0;
    val = 1'b0;
    for (int k = 0; k < LITS; k++) begin
      s = c[k*SW +: SW];
      if (s[SW-1]) begin
        vr = int'(s[VB-1:0]);
        if (vuna[vr]) begin
          nun++;
          v = vr;
          val = !s[SW-2];
        end else if (vval[vr] != s[SW-2]) begin
          sat = 1'b1;
        end
      end
    end
    if (sat || nun >= 2) kind = 0;
    else if (nun == 1) kind = 1;
    else kind = 2;
  endfunction

  task automatic plan(input int idx);
    int kind, v;
    bit val;
    if (!m_conf) begin
      exp_rd.push_back(idx);
      eval_clause(idx, kind, v, val);
      if (kind == 1) exp_push.push_back(v * 2 + int'(val));
      if (kind == 2) m_conf = 1'b1;
    end
  endtask

  task automatic strobe(input int idx);
    @(negedge clock);
    bcp_en = 1'b1;
    bcp_clause_idx = CB'(idx);
  endtask

  task automatic end_strobes();
    @(negedge clock);
    bcp_en = 1'b0;
  endtask

  task automatic pulse_reset_bcp();
    @(negedge clock);
    reset_bcp = 1'b1;
    @(negedge clock);
    reset_bcp = 1'b0;
    m_conf = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, input bit rnd_full);
    cyc = 0;
    while (bcp_busy && cyc < 3000) begin
      if (rnd_full) full_imply = ($urandom_range(0, 3) == 0);
      cyc++;
      @(negedge clock);
    end
    if (bcp_busy) fail_timeout("wait_idle");
    full_imply = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_imply(input int v, input string nm);
    int c;
    c = 0;
    while (var_in_imply != VB'(v) && c < 100) begin
      c++;
      @(negedge clock);
    end
    if (var_in_imply != VB'(v)) fail_timeout(nm);
  endtask

  task automatic chk_drained(input string nm);
    chk({nm, "_reads_left"}, exp_rd.size(), 0);
    chk({nm, "_pushes_left"}, exp_push.size(), 0);
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (cdb_read) begin
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read actual=%0d required=none", cdb_addr);
        end else begin
          chk("read_addr", 32'(cdb_addr), exp_rd.pop_front());
        end
      end
      if (push_imply) begin
        n_push++;
        if (exp_push.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_push actual=%0d/%0d required=none", var_in_imply, val_in_imply);
        end else begin
          chk("push_var_val", 32'({var_in_imply, val_in_imply}), exp_push.pop_front());
        end
        chk("push_type", 32'(type_in_imply), 1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, p0, n;
    int idxs[$];

    for (int i = 0; i < 256; i++) cmem[i] = '0;
    for (int i = 0; i < 64; i++) begin
      vval[i] = 1'b0;
      vuna[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(bcp_busy), 0);
    chk("rst_conflict", 32'(conflict), 0);
    chk("rst_overflow", 32'(bcp_overflow), 0);
    chk("rst_cdb_read", 32'(cdb_read), 0);
    chk("rst_read_vs", 32'(read_vs), 0);
    chk("rst_push", 32'(push_imply), 0);
    chk("rst_cdb_addr", 32'(cdb_addr), 0);
    chk("rst_var_in_vs", 32'(var_in_vs), 0);
    chk("rst_var_imply", 32'(var_in_imply), 0);
    chk("rst_val_imply", 32'(val_in_imply), 0);
    chk("rst_type_imply", 32'(type_in_imply), 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("post_rst_busy", 32'(bcp_busy), 0);

    // Two unassigned literals: no push, no conflict, 9 busy cycles.
    vval[5] = 1'b0; vuna[7] = 1'b1; vuna[9] = 1'b1;
    cmem[1] = cls(lit(1, 0, 5), lit(1, 1, 7), lit(1, 0, 9));
    p0 = n_push;
    plan(1);
    strobe(1);
    end_strobes();
    wait_idle(cyc, 1'b0);
    chk("t1_busy_cycles", cyc, 9);
    chk("t1_no_push", n_push - p0, 0);
    chk("t1_conflict", 32'(conflict), 0);
    chk_drained("t1");

    // Unit clause: exactly one push of var 4 value 0, 10 busy cycles.
    vval[2] = 1'b0; vval[3] = 1'b1; vuna[4] = 1'b1;
    cmem[2] = cls(lit(1, 0, 2), lit(1, 1, 3), lit(1, 1, 4));
    p0 = n_push;
    plan(2);
    strobe(2);
    end_strobes();
    wait_idle(cyc, 1'b0);
    chk("t2_busy_cycles", cyc, 10);
    chk("t2_one_push", n_push - p0, 1);
    chk("t2_conflict", 32'(conflict), 0);
    chk_drained("t2");

    // Conflict with three more queued: flush, remaining clauses not read.
    vval[1] = 1'b1; vval[6] = 1'b0;
    cmem[3] = cls(lit(1, 1, 1), lit(1, 0, 6), lit(0, 0, 0));
    idxs = '{3, 1, 2, 1};
    foreach (idxs[i]) plan(idxs[i]);
    foreach (idxs[i]) strobe(idxs[i]);
    end_strobes();
    wait_idle(cyc, 1'b0);
    chk("t3_conflict", 32'(conflict), 1);
    chk("t3_busy", 32'(bcp_busy), 0);
    chk("t3_overflow", 32'(bcp_overflow), 0);
    chk_drained("t3");
    plan(2);
    strobe(2);
    end_strobes();
    repeat (3) @(negedge clock);
    chk("t3_dropped_busy", 32'(bcp_busy), 0);
    chk("t3_dropped_no_ovf", 32'(bcp_overflow), 0);
    pulse_reset_bcp();
    chk("t3_conflict_cleared", 32'(conflict), 0);

    // Imply queue full for 5 cycles: data stable, push right after release.
    vval[10] = 1'b0; vuna[11] = 1'b1;
    cmem[4] = cls(lit(1, 0, 10), lit(1, 0, 11), lit(0, 0, 0));
    full_imply = 1'b1;
    plan(4);
    strobe(4);
    end_strobes();
    wait_imply(11, "t5_enter_push");
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_no_push", 32'(push_imply), 0);
      chk("t5_stall_data", 32'({var_in_imply, val_in_imply}), 23);
      @(negedge clock);
    end
    full_imply = 1'b0;
    @(negedge clock);
    chk("t5_push_after_release", 32'(push_imply), 1);
    wait_idle(cyc, 1'b0);
    chk_drained("t5");

    // Queue overflow: engine parked in a stall, 9 strobes, 9th dropped.
    vuna[12] = 1'b1;
    cmem[6] = cls(lit(1, 0, 12), '0, '0);
    for (int i = 0; i < 9; i++) begin
      vuna[20 + i] = 1'b1;
      cmem[10 + i] = cls(lit(1, i[0], 20 + i), '0, '0);
    end
    full_imply = 1'b1;
    plan(6);
    strobe(6);
    end_strobes();
    wait_imply(12, "t4_enter_push");
    for (int i = 0; i < 8; i++) plan(10 + i);
    for (int i = 0; i < 9; i++) strobe(10 + i);
    end_strobes();
    chk("t4_overflow", 32'(bcp_overflow), 1);
    chk("t4_busy", 32'(bcp_busy), 1);
    full_imply = 1'b0;
    wait_idle(cyc, 1'b0);
    chk("t4_overflow_sticky", 32'(bcp_overflow), 1);
    chk_drained("t4");
    pulse_reset_bcp();
    chk("t4_overflow_cleared", 32'(bcp_overflow), 0);

    // reset_bcp during literal evaluation of a unit clause.
    vuna[30] = 1'b1; vval[31] = 1'b0;
    cmem[5] = cls(lit(1, 1, 30), lit(1, 0, 31), '0);
    p0 = n_push;
    exp_rd.push_back(5);
    strobe(5);
    end_strobes();
    cyc = 0;
    while (!read_vs && cyc < 50) begin
      cyc++;
      @(negedge clock);
    end
    if (!read_vs) fail_timeout("t6_lit_eval");
    reset_bcp = 1'b1;
    @(negedge clock);
    reset_bcp = 1'b0;
    chk("t6_busy", 32'(bcp_busy), 0);
    chk("t6_conflict", 32'(conflict), 0);
    chk("t6_read_vs", 32'(read_vs), 0);
    repeat (12) @(negedge clock);
    chk("t6_no_push", n_push - p0, 0);
    chk("t6_still_idle", 32'(bcp_busy), 0);
    plan(2);
    strobe(2);
    end_strobes();
    wait_idle(cyc, 1'b0);
    chk("t6_followup_push", n_push - p0, 1);
    chk_drained("t6");

    // Randomized batches against the reference model.
    for (int b = 0; b < 25; b++) begin
      for (int v = 0; v < 64; v++) begin
        vuna[v] = ($urandom_range(0, 9) < 3);
        vval[v] = 1'($urandom_range(0, 1));
      end
      for (int i = 64; i < 128; i++) begin
        cmem[i] = cls(lit($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom_range(0, 15)),
                      lit($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom_range(0, 15)),
                      lit($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom_range(0, 15)));
      end
      n = $urandom_range(1, QDEPTH);
      idxs.delete();
      for (int i = 0; i < n; i++) idxs.push_back($urandom_range(64, 127));
      foreach (idxs[i]) plan(idxs[i]);
      foreach (idxs[i]) strobe(idxs[i]);
      end_strobes();
      wait_idle(cyc, b[0]);
      chk("rnd_conflict", 32'(conflict), 32'(m_conf));
      chk("rnd_overflow", 32'(bcp_overflow), 0);
      chk_drained("rnd");
      pulse_reset_bcp();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
